// File: rtl/icache_refill_unit.sv
// Line-fill engine behind the instruction cache: fetches one cache line as BEATS narrow bus
// beats, assembles them and returns the full line with a one-cycle ready pulse.
module icache_refill_unit #(
   parameter int BUS_W  = 32,
   parameter int LINE_W = 128,
   parameter int BEAT_B = BUS_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   input  logic [31:0]       req_addr_i,
   output logic              ready_o,
   output logic [LINE_W-1:0] line_o,
   output logic              busy_o,
   output logic              bus_req_o,
   output logic [31:0]       bus_addr_o,
   input  logic              bus_ack_i,
   input  logic [BUS_W-1:0]  bus_rdata_i
);

   localparam int BEATS = LINE_W / BUS_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam int BUF_W = LINE_W - BUS_W;
   localparam logic [31:0]      LINE_MASK = ~(32'(LINE_W / 8) - 32'd1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  beat_cnt, beat_cnt_n;
   logic [BUF_W-1:0]  asm_buf, asm_buf_n;
   logic [31:0]       bus_addr_n;
   logic [LINE_W-1:0] line_n;
   logic              ready_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         beat_cnt   <= '0;
         asm_buf    <= '0;
         bus_addr_o <= '0;
         line_o     <= '0;
         ready_o    <= 1'b0;
      end else begin
         state      <= state_n;
         beat_cnt   <= beat_cnt_n;
         asm_buf    <= asm_buf_n;
         bus_addr_o <= bus_addr_n;
         line_o     <= line_n;
         ready_o    <= ready_n;
      end
   end

   always_comb begin
      state_n    = state;
      beat_cnt_n = beat_cnt;
      asm_buf_n  = asm_buf;
      bus_addr_n = bus_addr_o;
      line_n     = line_o;
      ready_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid_i) begin
               state_n    = FILL;
               beat_cnt_n = '0;
               bus_addr_n = req_addr_i & LINE_MASK;
            end
         end
         FILL: begin
            // A redirect wins over any beat acknowledged in the same cycle, including the last.
            if (req_valid_i) begin
               beat_cnt_n = '0;
               bus_addr_n = req_addr_i & LINE_MASK;
            end else if (bus_ack_i) begin
               if (beat_cnt == LAST_BEAT) begin
                  line_n     = {bus_rdata_i, asm_buf};
                  ready_n    = 1'b1;
                  state_n    = IDLE;
                  beat_cnt_n = '0;
               end else begin
                  asm_buf_n[BUS_W*int'(beat_cnt) +: BUS_W] = bus_rdata_i;
                  beat_cnt_n = beat_cnt + CNT_W'(1);
                  bus_addr_n = bus_addr_o + 32'(BEAT_B);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy_o    = (state == FILL);
   assign bus_req_o = (state == FILL);

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit: inputs driven and outputs sampled on the falling edge.
module tb_icache_refill_unit;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid_i;
   logic [31:0]  req_addr_i;
   logic         ready_o;
   logic [127:0] line_o;
   logic         busy_o;
   logic         bus_req_o;
   logic [31:0]  bus_addr_o;
   logic         bus_ack_i;
   logic [31:0]  bus_rdata_i;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   icache_refill_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid_i),
      .req_addr_i  (req_addr_i),
      .ready_o     (ready_o),
      .line_o      (line_o),
      .busy_o      (busy_o),
      .bus_req_o   (bus_req_o),
      .bus_addr_o  (bus_addr_o),
      .bus_ack_i   (bus_ack_i),
      .bus_rdata_i (bus_rdata_i)
   );

   task automatic test_reset();
      rst_n = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ready_o, busy_o, bus_req_o} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl got %b want 000", {ready_o, busy_o, bus_req_o});
      end
      checks++;
      if (line_o !== 128'h0) begin errors++; $display("FAIL reset_line got %h want 0", line_o); end
      checks++;
      if (bus_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus_addr_o); end
      rst_n = 1'b1;
      @(negedge clk); bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
      @(negedge clk); bus_ack_i = 1'b0;
      checks++;
      if ({ready_o, busy_o, bus_req_o} !== 3'b000) begin
         errors++; $display("FAIL idle_ack got %b want 000", {ready_o, busy_o, bus_req_o});
      end
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b0 || line_o !== 128'h0) begin
         errors++; $display("FAIL idle_ack_line got ready=%b line=%h want ready=0 line=0", ready_o, line_o);
      end
   endtask

   task automatic test_basic();
      req_valid_i = 1'b1; req_addr_i = 32'h0000_1238;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_valid_i = 1'b0;
         checks++;
         if (bus_addr_o !== 32'h1230 + 32'(4*k) || bus_req_o !== 1'b1 || busy_o !== 1'b1 || ready_o !== 1'b0) begin
            errors++; $display("FAIL basic_beat%0d got addr=%h req=%b busy=%b ready=%b want addr=%h 1 1 0",
                               k, bus_addr_o, bus_req_o, busy_o, ready_o, 32'h1230 + 32'(4*k));
         end
         bus_ack_i = 1'b1; bus_rdata_i = 32'(17 * (k + 1));
      end
      @(negedge clk); bus_ack_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || busy_o !== 1'b0 || bus_req_o !== 1'b0) begin
         errors++; $display("FAIL basic_done got ready=%b busy=%b req=%b want 1 0 0", ready_o, busy_o, bus_req_o);
      end
      checks++;
      if (line_o !== 128'h00000044_00000033_00000022_00000011) begin
         errors++; $display("FAIL basic_line got %h want 00000044000000330000002200000011", line_o);
      end
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b0 || line_o !== 128'h00000044_00000033_00000022_00000011) begin
         errors++; $display("FAIL basic_hold got ready=%b line=%h want ready=0 line held", ready_o, line_o);
      end
   endtask

   task automatic test_gaps();
      req_valid_i = 1'b1; req_addr_i = 32'h4000_001F;
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            req_valid_i = 1'b0;
            checks++;
            if (bus_addr_o !== 32'h4000_0010 + 32'(4*k) || bus_req_o !== 1'b1 || ready_o !== 1'b0) begin
               errors++; $display("FAIL gaps_beat%0d_%0d got addr=%h req=%b ready=%b want addr=%h 1 0",
                                  k, g, bus_addr_o, bus_req_o, ready_o, 32'h4000_0010 + 32'(4*k));
            end
            bus_ack_i = (g == 2); bus_rdata_i = 32'hA0A0_0000 + 32'(k);
         end
      end
      @(negedge clk); bus_ack_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || busy_o !== 1'b0 || line_o !== 128'hA0A00003_A0A00002_A0A00001_A0A00000) begin
         errors++; $display("FAIL gaps_done got ready=%b busy=%b line=%h want 1 0 a0a00003a0a00002a0a00001a0a00000",
                            ready_o, busy_o, line_o);
      end
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b0) begin errors++; $display("FAIL gaps_pulse got ready=%b want 0", ready_o); end
   endtask

   task automatic test_abort();
      req_valid_i = 1'b1; req_addr_i = 32'h0000_0100;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req_valid_i = 1'b0;
         checks++;
         if (bus_addr_o !== 32'h100 + 32'(4*k)) begin
            errors++; $display("FAIL abort_old%0d got addr=%h want %h", k, bus_addr_o, 32'h100 + 32'(4*k));
         end
         bus_ack_i = 1'b1; bus_rdata_i = 32'hBAD0_0000 + 32'(k);
      end
      req_valid_i = 1'b1; req_addr_i = 32'h0000_0200;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_valid_i = 1'b0;
         checks++;
         if (bus_addr_o !== 32'h200 + 32'(4*k) || bus_req_o !== 1'b1 || ready_o !== 1'b0) begin
            errors++; $display("FAIL abort_new%0d got addr=%h req=%b ready=%b want addr=%h 1 0",
                               k, bus_addr_o, bus_req_o, ready_o, 32'h200 + 32'(4*k));
         end
         bus_ack_i = 1'b1; bus_rdata_i = 32'h2000_0000 + 32'(k);
      end
      @(negedge clk); bus_ack_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || line_o !== 128'h20000003_20000002_20000001_20000000) begin
         errors++; $display("FAIL abort_line got ready=%b line=%h want 1 20000003200000022000000120000000", ready_o, line_o);
      end
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b0) begin errors++; $display("FAIL abort_pulse got ready=%b want 0", ready_o); end
   endtask

   task automatic test_abort_last();
      req_valid_i = 1'b1; req_addr_i = 32'h0000_0100;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_valid_i = 1'b0;
         bus_ack_i = 1'b1; bus_rdata_i = 32'hCC00_0000 + 32'(k);
      end
      req_valid_i = 1'b1; req_addr_i = 32'h0000_0300;
      @(negedge clk);
      req_valid_i = 1'b0;
      checks++;
      if (ready_o !== 1'b0 || busy_o !== 1'b1 || bus_addr_o !== 32'h300) begin
         errors++; $display("FAIL abortlast_restart got ready=%b busy=%b addr=%h want 0 1 00000300", ready_o, busy_o, bus_addr_o);
      end
      checks++;
      if (line_o !== 128'h20000003_20000002_20000001_20000000) begin
         errors++; $display("FAIL abortlast_hold got %h want 20000003200000022000000120000000", line_o);
      end
      bus_ack_i = 1'b1; bus_rdata_i = 32'h3000_0000;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (bus_addr_o !== 32'h300 + 32'(4*k) || ready_o !== 1'b0) begin
            errors++; $display("FAIL abortlast_beat%0d got addr=%h ready=%b want %h 0", k, bus_addr_o, ready_o, 32'h300 + 32'(4*k));
         end
         bus_rdata_i = 32'h3000_0000 + 32'(k);
      end
      @(negedge clk); bus_ack_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || line_o !== 128'h30000003_30000002_30000001_30000000) begin
         errors++; $display("FAIL abortlast_line got ready=%b line=%h want 1 30000003300000023000000130000000", ready_o, line_o);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      req_valid_i = 1'b1; req_addr_i = 32'h0000_0500;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_valid_i = 1'b0;
         bus_ack_i = 1'b1; bus_rdata_i = 32'h5000_0000 + 32'(k);
      end
      @(negedge clk); bus_ack_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || line_o !== 128'h50000003_50000002_50000001_50000000) begin
         errors++; $display("FAIL b2b_first got ready=%b line=%h want 1 50000003500000025000000150000000", ready_o, line_o);
      end
      req_valid_i = 1'b1; req_addr_i = 32'h0000_0604;
      @(negedge clk);
      req_valid_i = 1'b0;
      checks++;
      if (bus_req_o !== 1'b1 || busy_o !== 1'b1 || bus_addr_o !== 32'h600 || ready_o !== 1'b0) begin
         errors++; $display("FAIL b2b_restart got req=%b busy=%b addr=%h ready=%b want 1 1 00000600 0",
                            bus_req_o, busy_o, bus_addr_o, ready_o);
      end
      bus_ack_i = 1'b1; bus_rdata_i = 32'h6000_0000;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         bus_rdata_i = 32'h6000_0000 + 32'(k);
      end
      @(negedge clk); bus_ack_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || line_o !== 128'h60000003_60000002_60000001_60000000) begin
         errors++; $display("FAIL b2b_second got ready=%b line=%h want 1 60000003600000026000000160000000", ready_o, line_o);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid_i = 1'b1; req_addr_i = 32'h0000_0700;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         req_valid_i = 1'b0;
         bus_ack_i = 1'b1; bus_rdata_i = 32'h7000_0000 + 32'(k);
      end
      @(negedge clk);
      bus_ack_i = 1'b0;
      checks++;
      if (bus_addr_o !== 32'h708) begin errors++; $display("FAIL rstmid_pre got addr=%h want 00000708", bus_addr_o); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ready_o, busy_o, bus_req_o} !== 3'b000 || bus_addr_o !== 32'h0 || line_o !== 128'h0) begin
         errors++; $display("FAIL rstmid_async got ready=%b busy=%b req=%b addr=%h line=%h want all 0",
                            ready_o, busy_o, bus_req_o, bus_addr_o, line_o);
      end
      @(negedge clk);
      rst_n = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'hEEEE_EEEE;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({ready_o, busy_o, bus_req_o} !== 3'b000 || line_o !== 128'h0) begin
            errors++; $display("FAIL rstmid_after%0d got ready=%b busy=%b req=%b line=%h want 0 0 0 0",
                               k, ready_o, busy_o, bus_req_o, line_o);
         end
      end
      bus_ack_i = 1'b0; req_valid_i = 1'b1; req_addr_i = 32'h0000_0800;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_valid_i = 1'b0;
         bus_ack_i = 1'b1; bus_rdata_i = 32'h8000_0000 + 32'(k);
      end
      @(negedge clk); bus_ack_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || line_o !== 128'h80000003_80000002_80000001_80000000) begin
         errors++; $display("FAIL rstmid_refill got ready=%b line=%h want 1 80000003800000028000000180000000", ready_o, line_o);
      end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_basic();
      @(negedge clk);
      test_gaps();
      @(negedge clk);
      test_abort();
      @(negedge clk);
      test_abort_last();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
